uart_pkt_ctrl: RTL and testbench

Packet controller that sits behind the UART receiver. It consumes the receiver's byte stream (rx_data/rx_valid) and parses framed write packets. Payload is buffered until the checksum is verified, then committed as a burst of single-cycle register writes into the control register file. Malformed, stalled or overrun traffic is reported through error pulses and a code.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_pkt_buf.sv | 25 ++
 rtl/uart_pkt_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART packet controller: FSM states, error codes and
// the default frame start marker.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_LEN  = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_COMMIT   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_BADLEN  = 2'd1,
        ERR_CHKSUM  = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload holding buffer: written one byte per accepted data byte, read back
// by index while the packet is committed. Contents need no reset.
module uart_pkt_buf #(
    parameter int MAX_LEN = 8,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Framed write-packet parser behind the UART receiver. Payload is held until
// the checksum matches, then replayed as a burst of register writes.
module uart_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int         ADDR_W         = 4,
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              busy,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic [1:0]        err_code
);

    localparam int         IW        = $clog2(MAX_LEN + 1);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ctrl_state_t       r_state, w_state_nx;
    logic [IW-1:0]     r_idx, w_idx_nx;
    logic [IW-1:0]     r_len, w_len_nx;
    logic [ADDR_W-1:0] r_base, w_base_nx;
    logic [7:0]        r_chk, w_chk_nx;
    logic [TW-1:0]     r_tmo, w_tmo_nx;
    logic              r_wr_en, w_wr_en_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_wdata, w_wdata_nx;
    logic              r_busy;
    logic              r_ok, w_ok_nx;
    logic              r_err, w_err_nx;
    err_code_t         r_code, w_code_nx;

    logic              w_buf_we;
    logic [AW-1:0]     w_rd_idx;
    logic [7:0]        w_rd_data;
    logic              w_tmo_hit;
    logic              w_in_frame;

    uart_pkt_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_buf_we),
        .i_wr_idx  (r_idx[AW-1:0]),
        .i_wr_data (rx_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_COMMIT);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_len_nx   = r_len;
        w_base_nx  = r_base;
        w_chk_nx   = r_chk;
        w_tmo_nx   = '0;
        w_wr_en_nx = 1'b0;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_ok_nx    = 1'b0;
        w_err_nx   = 1'b0;
        w_code_nx  = r_code;
        w_buf_we   = 1'b0;
        w_rd_idx   = '0;
        w_tmo_hit  = 1'b0;

        // Inter-byte gap timer; it only runs while a frame is being received.
        if (w_in_frame && !rx_valid) begin
            if (r_tmo == TMO_LAST) begin
                w_tmo_hit = 1'b1;
            end else begin
                w_tmo_nx = r_tmo + 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    w_state_nx = ST_GET_ADDR;
                    w_chk_nx   = '0;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    w_base_nx  = rx_data[ADDR_W-1:0];
                    w_chk_nx   = r_chk ^ rx_data;
                    w_state_nx = ST_GET_LEN;
                end
            end
            ST_GET_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        w_err_nx   = 1'b1;
                        w_code_nx  = ERR_BADLEN;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_len_nx   = rx_data[IW-1:0];
                        w_chk_nx   = r_chk ^ rx_data;
                        w_idx_nx   = '0;
                        w_state_nx = ST_GET_DATA;
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    w_buf_we = 1'b1;
                    w_chk_nx = r_chk ^ rx_data;
                    w_idx_nx = r_idx + 1'b1;
                    if (r_idx == r_len - 1'b1) begin
                        w_state_nx = ST_GET_CHK;
                    end
                end
            end
            ST_GET_CHK: begin
                if (rx_valid) begin
                    if (rx_data != r_chk) begin
                        w_err_nx   = 1'b1;
                        w_code_nx  = ERR_CHKSUM;
                        w_state_nx = ST_IDLE;
                    end else begin
                        // First write is launched on the checksum edge itself.
                        w_rd_idx   = '0;
                        w_wr_en_nx = 1'b1;
                        w_addr_nx  = r_base;
                        w_wdata_nx = w_rd_data;
                        w_idx_nx   = IW'(1);
                        w_state_nx = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                w_rd_idx = r_idx[AW-1:0];
                if (r_idx == r_len) begin
                    w_ok_nx    = 1'b1;
                    w_idx_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_wr_en_nx = 1'b1;
                    w_addr_nx  = r_base + ADDR_W'(r_idx);
                    w_wdata_nx = w_rd_data;
                    w_idx_nx   = r_idx + 1'b1;
                end
                if (rx_valid) begin
                    w_err_nx  = 1'b1;
                    w_code_nx = ERR_OVERRUN;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_err_nx   = 1'b1;
            w_code_nx  = ERR_TIMEOUT;
            w_state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_base  <= '0;
            r_chk   <= '0;
            r_tmo   <= '0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_TIMEOUT;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_len   <= w_len_nx;
            r_base  <= w_base_nx;
            r_chk   <= w_chk_nx;
            r_tmo   <= w_tmo_nx;
            r_wr_en <= w_wr_en_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
            r_ok    <= w_ok_nx;
            r_err   <= w_err_nx;
            r_code  <= w_code_nx;
        end
    end

    assign reg_wr_en = r_wr_en;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign busy      = r_busy;
    assign pkt_ok    = r_ok;
    assign pkt_err   = r_err;
    assign err_code  = r_code;

    a_wr_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        reg_wr_en |-> busy);
    a_ok_not_writing: assert property (@(posedge clk) disable iff (!rst_n)
        pkt_ok |-> !reg_wr_en);

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Self-checking bench for uart_pkt_ctrl: byte-level driver, cycle-accurate
// scoreboard of register writes, completion and error pulses.
module tb_uart_pkt_ctrl;

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [1:0] C_TMO    = 2'd0;
    localparam logic [1:0] C_BADLEN = 2'd1;
    localparam logic [1:0] C_CHKSUM = 2'd2;
    localparam logic [1:0] C_OVR    = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_edge = 0;

    logic [11:0] exp_q[$];
    int          exp_wr_cyc_q[$];
    int          exp_ok_cyc_q[$];
    logic [1:0]  exp_err_q[$];
    int          exp_err_cyc_q[$];
    logic [7:0]  pl [8];

    uart_pkt_ctrl #(
        .ADDR_W         (4),
        .MAX_LEN        (8),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reg_wr_en (reg_wr_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .pkt_ok    (pkt_ok),
        .pkt_err   (pkt_err),
        .err_code  (err_code)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Driver: byte presented from a negedge, sampled at the next posedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
    endtask

    task automatic push_err(input logic [1:0] code, input int edge_n);
        exp_err_q.push_back(code);
        exp_err_cyc_q.push_back(edge_n);
    endtask

    task automatic send_frame(input logic [7:0] addr, input int len, input logic [7:0] corrupt);
        logic [7:0] c;
        logic [3:0] a;
        c = addr ^ 8'(len);
        send_byte(SYNC);
        send_byte(addr);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i]);
            c = c ^ pl[i];
        end
        send_byte(c ^ corrupt);
        if (corrupt == 8'h00) begin
            for (int i = 0; i < len; i++) begin
                a = addr[3:0] + 4'(i);
                exp_q.push_back({a, pl[i]});
                exp_wr_cyc_q.push_back(last_edge + i);
            end
            exp_ok_cyc_q.push_back(last_edge + len);
        end else begin
            push_err(C_CHKSUM, last_edge);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Scoreboard: every output pulse must match the head of its queue
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", {reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            end else begin
                check_eq("wr_addr_data", {reg_addr, reg_wdata}, exp_q.pop_front());
                check_eq("wr_cycle", cyc, exp_wr_cyc_q.pop_front());
            end
        end
        if (pkt_err === 1'b1) begin
            if (exp_err_q.size() == 0) begin
                check_eq("err_unexpected", err_code, 32'hFFFF_FFFF);
            end else begin
                logic [1:0] ec;
                ec = exp_err_q.pop_front();
                check_eq("err_code", err_code, ec);
                check_eq("err_cycle", cyc, exp_err_cyc_q.pop_front());
                if (ec != C_OVR) check_eq("err_busy", busy, 0);
            end
        end
        if (pkt_ok === 1'b1) begin
            if (exp_ok_cyc_q.size() == 0) begin
                check_eq("ok_unexpected", pkt_ok, 0);
            end else begin
                check_eq("ok_cycle", cyc, exp_ok_cyc_q.pop_front());
                check_eq("ok_busy", busy, 0);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        @(negedge clk);
        check_eq("rst_wr_en", reg_wr_en, 0);
        check_eq("rst_addr", reg_addr, 0);
        check_eq("rst_wdata", reg_wdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ok", pkt_ok, 0);
        check_eq("rst_err", pkt_err, 0);
        check_eq("rst_code", err_code, 0);
        rst_n = 1'b1;

        // Leading garbage, then the basic good packet
        send_byte(8'h12);
        send_byte(8'h34);
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h03, 2, 8'h00);
        idle(5);

        // Address wraps from F to 0
        pl[0] = 8'hAA; pl[1] = 8'hBB;
        send_frame(8'h0F, 2, 8'h00);
        idle(5);

        // Bad checksum then a good single-byte packet
        pl[0] = 8'h11; pl[1] = 8'h22;
        send_frame(8'h03, 2, 8'h01);
        @(negedge clk);
        check_eq("chk_busy_drop", busy, 0);
        pl[0] = 8'h5A;
        send_frame(8'h01, 1, 8'h00);
        idle(4);
        check_eq("err_code_hold", err_code, C_CHKSUM);

        // LEN errors with garbage in front
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h00);
        push_err(C_BADLEN, last_edge);
        idle(3);
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h09);
        push_err(C_BADLEN, last_edge);
        idle(3);

        // Inter-byte timeout
        send_byte(SYNC);
        check_eq("busy_in_frame", busy, 1);
        send_byte(8'h07);
        push_err(C_TMO, last_edge + 50);
        idle(60);
        pl[0] = 8'h3C; pl[1] = 8'hC3; pl[2] = 8'hA5;
        send_frame(8'h07, 3, 8'h00);
        idle(6);

        // Random packets, including in-payload SYNC values
        for (int k = 0; k < 5; k++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) pl[i] = 8'($urandom_range(0, 255));
            send_frame(8'($urandom_range(0, 255)), len, 8'h00);
            idle($urandom_range(0, 3) + len + 2);
        end

        // Reset in the middle of a packet
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_code", err_code, 0);
        send_byte(8'h22);
        send_byte(8'h32);
        idle(5);
        check_eq("post_rst_busy", busy, 0);

        // Overrun during a full-length commit
        for (int i = 0; i < 8; i++) pl[i] = 8'(8'h40 + i);
        send_frame(8'h05, 8, 8'h00);
        idle(2);
        send_byte(8'h3C);
        push_err(C_OVR, last_edge);
        idle(10);

        // Overrun landing on the commit's final edge: both pulses together
        pl[0] = 8'hDE; pl[1] = 8'hAD;
        send_frame(8'h0E, 2, 8'h00);
        idle(1);
        send_byte(8'h77);
        push_err(C_OVR, last_edge);
        idle(6);

        check_eq("wr_left", exp_q.size(), 0);
        check_eq("ok_left", exp_ok_cyc_q.size(), 0);
        check_eq("err_left", exp_err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
